mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM (1-cycle registered read, byte-enabled write)
//   between the instruction-fetch port and the data (load/store) port.
//   Data requests have priority. A streak counter guarantees that fetch is never
//   starved. Requests are pipelined: one grant per cycle, response one cycle after grant.
//   Sits between the IF/MEM pipeline stages and the shared memory instance.
// PARAMETERS
//   MAX_DSTREAK  4  max consecutive data grants while fetch waits; then fetch gets one grant (>=1)
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   synchronous active-high reset
//   if_req_valid   in   1   fetch read request
//   if_req_addr    in   32  fetch byte address (word-aligned)
//   if_req_ready   out  1   fetch request granted this cycle
//   if_resp_valid  out  1   fetch read data valid
//   if_resp_rdata  out  32  fetch read data
//   d_req_valid    in   1   data request
//   d_req_we       in   1   1=store, 0=load
//   d_req_be       in   4   store byte enables
//   d_req_addr     in   32  data byte address (word-aligned)
//   d_req_wdata    in   32  store data
//   d_req_ready    out  1   data request granted this cycle
//   d_resp_valid   out  1   load data valid / store complete
//   d_resp_rdata   out  32  load data (don't-care on store ack)
//   mem_addr       out  32  to memory addr
//   mem_wdata      out  32  to memory wdata
//   mem_we         out  1   to memory we
//   mem_be         out  4   to memory be
//   mem_rdata      in   32  from memory rdata (registered inside memory)
// BEHAVIOUR
//   - Grant (combinational, same cycle):
//     - d_grant = d_req_valid & !(if_req_valid & streak==MAX_DSTREAK) & !rst
//     - if_grant = if_req_valid & !d_grant & !rst
//     - if_req_ready = if_grant; d_req_ready = d_grant. At most one grant per cycle.
//   - Handshake: transfer on valid&ready. The requester holds valid and its payload stable until
//     ready. Deasserting valid before ready is permitted and causes no memory access.
//   - Memory mux (combinational):
//     - d_grant: mem_addr/wdata/be from data port; mem_we = d_req_we.
//     - if_grant: mem_addr = if_req_addr, mem_wdata = 0, mem_be = 0, mem_we = 0.
//     - No grant: mem_addr = 0, mem_wdata = 0, mem_be = 0, mem_we = 0.
//   - Response: registered owner flags.
//     - if_resp_valid <= if_grant; d_resp_valid <= d_grant. This includes stores (ack).
//     - if_resp_rdata = d_resp_rdata = mem_rdata, passed through combinationally.
//     - Latency is exactly 1 cycle after the grant. Throughput is 1 access/cycle.
//     - There is no response backpressure; requesters always accept responses.
//   - Streak counter, width $clog2(MAX_DSTREAK+1), evaluated in this order:
//     - Cleared when if_grant, or when if_req_valid==0.
//     - Otherwise incremented when d_grant & if_req_valid, saturating at MAX_DSTREAK.
//     - Once at MAX_DSTREAK with both ports valid, fetch wins and the counter clears.
//     - With fetch idle, the data port is never throttled.
//   - Store then load to the same address in consecutive cycles returns the new data
//     (the memory writes at the grant edge). A fetch in the cycle after a store sees the stored word.
//   - Reset:
//     - Streak is cleared; if_resp_valid and d_resp_valid are cleared.
//     - While rst=1, both readies are 0 and mem_we=0.
//     - A grant in the cycle before rst produces no response valid in the rst cycle.
//     - Memory contents are not affected by reset.
// TESTING
//   1. Fetch only: if_req_valid=1 at addrs 0x0,0x4,0x8 on consecutive cycles -> ready every cycle;
//      if_resp_valid on the next 3 cycles with mem[0],mem[1],mem[2]; d_resp_valid stays 0.
//   2. Both valid in the same cycle with streak=0 -> d_req_ready=1, if_req_ready=0;
//      d_resp_valid next cycle. Fetch is granted the following cycle once data drops valid.
//   3. Both valid continuously for 10 cycles with MAX_DSTREAK=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
//   4. Store 0xDEADBEEF be=4'hF @0x40, then load @0x40 -> 0xDEADBEEF.
//      Store 0x0000AA00 be=4'h2 @0x40, then load -> 0xDEADAAEF. Each store gives d_resp_valid=1 one cycle later.
//   5. Reset mid-operation: rst=1 the cycle after a fetch grant -> if_resp_valid=0 in that cycle,
//      readies=0, mem_we=0, streak=0. First grant occurs the cycle rst deasserts.
//   6. Data valid, then fetch valid only (no data) -> streak clears; resp ownership tracks grant order.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request, response and shared-memory signal bundle
interface mem_port_arbiter_if;
    // Instruction-fetch port
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;

    // Data (load/store) port
    logic        d_req_valid;
    logic        d_req_we;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;

    // Shared single-port RAM
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        output if_req_ready,
        output if_resp_valid,
        output if_resp_rdata,
        input  d_req_valid,
        input  d_req_we,
        input  d_req_be,
        input  d_req_addr,
        input  d_req_wdata,
        output d_req_ready,
        output d_resp_valid,
        output d_resp_rdata,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_be,
        input  mem_rdata
    );

    // Pipeline stages plus memory instance side
    modport master (
        output if_req_valid,
        output if_req_addr,
        input  if_req_ready,
        input  if_resp_valid,
        input  if_resp_rdata,
        output d_req_valid,
        output d_req_we,
        output d_req_be,
        output d_req_addr,
        output d_req_wdata,
        input  d_req_ready,
        input  d_resp_valid,
        input  d_resp_rdata,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one single-port synchronous RAM
module mem_port_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus_if
);
    // Streak counter counts 0..MAX_DSTREAK inclusive.
    localparam int              SW         = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [SW-1:0]   STREAK_ONE = SW'(1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          if_resp_q;
    logic          if_resp_d;
    logic          d_resp_q;
    logic          d_resp_d;

    logic          fetch_starved;
    logic          d_grant;
    logic          if_grant;

    // Data wins unless fetch has waited through a full streak of data grants.
    always_comb begin
        fetch_starved = bus_if.if_req_valid && (streak_q == STREAK_MAX);
        d_grant       = bus_if.d_req_valid && !fetch_starved && !rst;
        if_grant      = bus_if.if_req_valid && !d_grant && !rst;
    end

    assign bus_if.d_req_ready  = d_grant;
    assign bus_if.if_req_ready = if_grant;

    // Steer the granted request onto the memory port; idle port drives all zeros.
    always_comb begin
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_be    = 4'h0;
        bus_if.mem_we    = 1'b0;
        if (d_grant) begin
            bus_if.mem_addr  = bus_if.d_req_addr;
            bus_if.mem_wdata = bus_if.d_req_wdata;
            bus_if.mem_be    = bus_if.d_req_be;
            bus_if.mem_we    = bus_if.d_req_we;
        end else if (if_grant) begin
            bus_if.mem_addr  = bus_if.if_req_addr;
        end
    end

    // Next-state: response owner flags follow the grant; streak tracks data wins while fetch waits.
    always_comb begin
        if_resp_d = if_grant;
        d_resp_d  = d_grant;
        streak_d  = streak_q;
        if (if_grant || !bus_if.if_req_valid) begin
            streak_d = '0;
        end else if (d_grant && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q  <= '0;
            if_resp_q <= 1'b0;
            d_resp_q  <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            if_resp_q <= if_resp_d;
            d_resp_q  <= d_resp_d;
        end
    end

    // A grant made just before reset must not surface as a response during the reset cycle.
    assign bus_if.if_resp_valid = if_resp_q && !rst;
    assign bus_if.d_resp_valid  = d_resp_q && !rst;

    // Memory read data is already registered inside the RAM; both ports see it directly.
    assign bus_if.if_resp_rdata = bus_if.mem_rdata;
    assign bus_if.d_resp_rdata  = bus_if.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_DSTREAK(MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural RAM on the memory side of the DUT
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end

    // Reference model: priority rules, waiting-fetch streak count, memory image, pending response
    logic [31:0] model_mem [0:255];
    int          dstreak    = 0;
    logic        pend_if    = 1'b0;
    logic        pend_d     = 1'b0;
    logic        pend_store = 1'b0;
    logic [31:0] pend_data  = 32'h0;

    function automatic logic gd(input logic r, input logic dv, input logic fv, input int s);
        return !r && dv && !(fv && s >= MAX);
    endfunction

    function automatic logic gf(input logic r, input logic dv, input logic fv, input int s);
        return !r && fv && !gd(r, dv, fv, s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            dstreak    <= 0;
            pend_if    <= 1'b0;
            pend_d     <= 1'b0;
            pend_store <= 1'b0;
        end else begin
            pend_if    <= gf(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak);
            pend_d     <= gd(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak);
            pend_store <= gd(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak) && bus.d_req_we;
            pend_data  <= gd(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak)
                          ? model_mem[bus.d_req_addr[9:2]] : model_mem[bus.if_req_addr[9:2]];
            if (gd(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak) && bus.d_req_we)
                for (int b = 0; b < 4; b++)
                    if (bus.d_req_be[b])
                        model_mem[bus.d_req_addr[9:2]][8*b +: 8] <= bus.d_req_wdata[8*b +: 8];
            if (!bus.if_req_valid || gf(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak))
                dstreak <= 0;
            else if (gd(1'b0, bus.d_req_valid, bus.if_req_valid, dstreak))
                dstreak <= dstreak + 1;
        end
    end

    // Compare process: every cycle, mid-cycle
    logic ed, ef;
    always @(negedge clk) begin
        ed = gd(rst, bus.d_req_valid, bus.if_req_valid, dstreak);
        ef = gf(rst, bus.d_req_valid, bus.if_req_valid, dstreak);
        chk("d_req_ready", {31'h0, bus.d_req_ready}, {31'h0, ed});
        chk("if_req_ready", {31'h0, bus.if_req_ready}, {31'h0, ef});
        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, ed && bus.d_req_we});
        chk("mem_addr", bus.mem_addr, ed ? bus.d_req_addr : (ef ? bus.if_req_addr : 32'h0));
        chk("mem_wdata", bus.mem_wdata, ed ? bus.d_req_wdata : 32'h0);
        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, (ed ? bus.d_req_be : 4'h0)});
        chk("if_resp_valid", {31'h0, bus.if_resp_valid}, {31'h0, pend_if && !rst});
        chk("d_resp_valid", {31'h0, bus.d_resp_valid}, {31'h0, pend_d && !rst});
        if (pend_if && !rst) chk("if_resp_rdata", bus.if_resp_rdata, pend_data);
        if (pend_d && !pend_store && !rst) chk("d_resp_rdata", bus.d_resp_rdata, pend_data);
    end

    // Stimulus helpers: drive just after the rising edge, literal checks before the falling edge
    task automatic drv(input logic r, input logic fv, input logic [31:0] fa,
                       input logic dv, input logic we, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd);
        rst              = r;
        bus.if_req_valid = fv;
        bus.if_req_addr  = fa;
        bus.d_req_valid  = dv;
        bus.d_req_we     = we;
        bus.d_req_be     = be;
        bus.d_req_addr   = da;
        bus.d_req_wdata  = wd;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    logic [9:0] pat3;
    logic [4:0] pat5;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 32'hA5A5_0000 | i;
            model_mem[i] = 32'hA5A5_0000 | i;
        end
        bus.mem_rdata = 32'h0;
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset_if_ready", {31'h0, bus.if_req_ready}, 32'h0);
        tick;
        chk("reset_if_resp", {31'h0, bus.if_resp_valid}, 32'h0);
        chk("reset_d_resp", {31'h0, bus.d_resp_valid}, 32'h0);
        tick;

        // 1. fetch only, three consecutive words
        drv(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t1_rdy0", {31'h0, bus.if_req_ready}, 32'h1);
        tick;
        drv(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t1_rdy1", {31'h0, bus.if_req_ready}, 32'h1);
        chk("t1_resp0_v", {31'h0, bus.if_resp_valid}, 32'h1);
        chk("t1_resp0_d", bus.if_resp_rdata, 32'hA5A5_0000);
        tick;
        drv(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t1_resp1_d", bus.if_resp_rdata, 32'hA5A5_0001);
        tick;
        idle;
        chk("t1_resp2_d", bus.if_resp_rdata, 32'hA5A5_0002);
        chk("t1_no_d_resp", {31'h0, bus.d_resp_valid}, 32'h0);
        tick;

        // 2. simultaneous requests: data first, fetch once data drops
        drv(1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        chk("t2_d_rdy", {31'h0, bus.d_req_ready}, 32'h1);
        chk("t2_if_rdy", {31'h0, bus.if_req_ready}, 32'h0);
        tick;
        drv(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t2_if_rdy2", {31'h0, bus.if_req_ready}, 32'h1);
        chk("t2_d_resp", bus.d_resp_rdata, 32'hA5A5_0004);
        tick;
        idle;
        chk("t2_if_resp", bus.if_resp_rdata, 32'hA5A5_0003);
        tick;

        // 3. both valid for ten cycles: D,D,D,D,F,D,D,D,D,F
        pat3 = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
            chk("t3_d_grant", {31'h0, bus.d_req_ready}, {31'h0, pat3[9-i]});
            chk("t3_f_grant", {31'h0, bus.if_req_ready}, {31'h0, !pat3[9-i]});
            tick;
        end
        idle;
        tick;

        // 4. store/load forwarding through memory, partial byte write, fetch after store
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        chk("t4_s1_we", {31'h0, bus.mem_we}, 32'h1);
        tick;
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        chk("t4_s1_ack", {31'h0, bus.d_resp_valid}, 32'h1);
        tick;
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h2, 32'h40, 32'h0000AA00);
        chk("t4_l1_data", bus.d_resp_rdata, 32'hDEADBEEF);
        tick;
        drv(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t4_s2_ack", {31'h0, bus.d_resp_valid}, 32'h1);
        tick;
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        chk("t4_fetch_data", bus.if_resp_rdata, 32'hDEADAAEF);
        tick;
        idle;
        chk("t4_l2_data", bus.d_resp_rdata, 32'hDEADAAEF);
        tick;

        // 5. reset the cycle after a fetch grant
        drv(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t5_if_rdy", {31'h0, bus.if_req_ready}, 32'h1);
        tick;
        drv(1'b1, 1'b1, 32'h50, 1'b1, 1'b1, 4'hF, 32'h80, 32'h12345678);
        chk("t5_rst_if_resp", {31'h0, bus.if_resp_valid}, 32'h0);
        chk("t5_rst_if_rdy", {31'h0, bus.if_req_ready}, 32'h0);
        chk("t5_rst_d_rdy", {31'h0, bus.d_req_ready}, 32'h0);
        chk("t5_rst_we", {31'h0, bus.mem_we}, 32'h0);
        tick;
        drv(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
        chk("t5_first_grant", {31'h0, bus.d_req_ready}, 32'h1);
        tick;
        pat5 = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
            chk("t5_streak", {31'h0, bus.d_req_ready}, {31'h0, pat5[4-i]});
            tick;
        end
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
        tick;
        idle;
        chk("t5_no_write", bus.d_resp_rdata, 32'hA5A5_0020);
        tick;

        // 6. streak clears when fetch drops; data unthrottled alone; ownership follows grants
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 32'h60, 1'b1, 1'b0, 4'h0, 32'h64, 32'h0);
            tick;
        end
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h64, 32'h0);
        tick;
        pat5 = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, 32'h60, 1'b1, 1'b0, 4'h0, 32'h64, 32'h0);
            chk("t6_streak_clr", {31'h0, bus.d_req_ready}, {31'h0, pat5[4-i]});
            tick;
        end
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h68, 32'h0);
            chk("t6_d_only", {31'h0, bus.d_req_ready}, 32'h1);
            tick;
        end
        drv(1'b0, 1'b1, 32'h6C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("t6_f_rdy", {31'h0, bus.if_req_ready}, 32'h1);
        chk("t6_d_owner", {31'h0, bus.d_resp_valid}, 32'h1);
        chk("t6_d_data", bus.d_resp_rdata, 32'hA5A5_001A);
        tick;
        idle;
        chk("t6_f_owner", {31'h0, bus.if_resp_valid}, 32'h1);
        chk("t6_d_clear", {31'h0, bus.d_resp_valid}, 32'h0);
        chk("t6_f_data", bus.if_resp_rdata, 32'hA5A5_001B);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
